// File: rtl/iter_shifter_pkg.sv
// Shared encodings and widths for the iterative shift/rotate unit.
package iter_shifter_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // S_IDLE must stay the all-zero encoding: the state dff resets to '0.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_shifter_dff.sv
// Standard register cell with synchronous active-high reset to zero.
module iter_shifter_dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d each rising edge; reset clears the register.
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/iter_shifter_flip.sv
// Bit-reversal block: y[i] = a[WIDTH-1-i].
module iter_shifter_flip
  import iter_shifter_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  // Mirror the operand bit order.
  always_comb begin
    y = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      y[i] = a[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle 16-bit ROL/SLL/ROR/SRL unit, one bit position per cycle.
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in,
  input  logic [CNT_W-1:0] amt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out
);

  state_t           state_q, state_d;
  logic [1:0]       state_bits_q;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] in_flip, work_flip;

  // Right ops reuse the left datapath: reverse on load and on unload.
  iter_shifter_flip u_flip_in  (.a(in),     .y(in_flip));
  iter_shifter_flip u_flip_out (.a(work_q), .y(work_flip));

  iter_shifter_dff #(.W(2))     u_state_q (.clk(clk), .rst(rst), .d(state_d), .q(state_bits_q));
  iter_shifter_dff #(.W(2))     u_op_q    (.clk(clk), .rst(rst), .d(op_d),    .q(op_q));
  iter_shifter_dff #(.W(CNT_W)) u_cnt_q   (.clk(clk), .rst(rst), .d(cnt_d),   .q(cnt_q));
  iter_shifter_dff #(.W(WIDTH)) u_work_q  (.clk(clk), .rst(rst), .d(work_d),  .q(work_q));
  iter_shifter_dff #(.W(WIDTH)) u_out_q   (.clk(clk), .rst(rst), .d(out_d),   .q(out_q));

  assign state_q = state_t'(state_bits_q);

  // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          work_d  = op[1] ? in_flip : in;
          cnt_d   = amt;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          work_d = op_q[0] ? {work_q[WIDTH-2:0], 1'b0}
                           : {work_q[WIDTH-2:0], work_q[WIDTH-1]};
          cnt_d  = cnt_q - CNT_W'(1);
        end else begin
          out_d   = op_q[1] ? work_flip : work_q;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign done  = (state_q == S_DONE);
  assign out   = out_q;

endmodule
